// File: rtl/mlaw_pkg.sv
// Shared constants and types for the linear-to-mu-law capture path.
// Bias and clip values follow the 13-bit G.711 mu-law magnitude scale.
package mlaw_pkg;

    localparam int MLAW_BIAS = 33;
    localparam int MLAW_CLIP = 8158;
    localparam logic [7:0] MLAW_SILENCE = 8'hFF;

    typedef logic [12:0] lin13_t;
    typedef logic [7:0]  mlaw8_t;

endpackage

// File: rtl/lin2mlaw_sync_if.sv
// Sample/flag bundle between the I2S capture side and the mu-law encoder.
// The master modport is the sample source; the slave modport is the encoder block.
interface lin2mlaw_sync_if;

    logic               avail_async;
    mlaw_pkg::lin13_t   lin_in;
    logic               avail_sync;
    mlaw_pkg::mlaw8_t   mlaw_out;
    logic               mlaw_stb;

    modport master (
        output avail_async,
        output lin_in,
        input  avail_sync,
        input  mlaw_out,
        input  mlaw_stb
    );

    modport slave (
        input  avail_async,
        input  lin_in,
        output avail_sync,
        output mlaw_out,
        output mlaw_stb
    );

endinterface

// File: rtl/lin2mlaw_enc.sv
// Purely combinational G.711 mu-law encoder: 13-bit two's-complement sample in, 8-bit byte out.
// One's-complement magnitude is used, so -4096 needs no overflow handling.
module lin2mlaw_enc
    import mlaw_pkg::*;
(
    input  lin13_t i_lin,
    output mlaw8_t o_mlaw
);

    logic        w_sign;
    logic [11:0] w_mag;
    logic [11:0] w_mh;
    logic [2:0]  w_seg;
    logic [3:0]  w_mant;

    assign w_sign = i_lin[12];
    assign w_mag  = w_sign ? ~i_lin[11:0] : i_lin[11:0];

    // The biased value 2*mag+33 is always odd, so only its bits [12:1] are carried:
    // bit j of w_mh is bit j+1 of the biased value, which equals mag+16 (or all ones when clipped).
    assign w_mh = (w_mag > 12'(MLAW_CLIP / 2)) ? 12'hFFF : w_mag + 12'(MLAW_BIAS / 2);

    always_comb begin
        w_seg = 3'd0;
        casez (w_mh[11:4])
            8'b1???????: w_seg = 3'd7;
            8'b01??????: w_seg = 3'd6;
            8'b001?????: w_seg = 3'd5;
            8'b0001????: w_seg = 3'd4;
            8'b00001???: w_seg = 3'd3;
            8'b000001??: w_seg = 3'd2;
            8'b0000001?: w_seg = 3'd1;
            default:     w_seg = 3'd0;
        endcase
    end

    always_comb begin
        w_mant = 4'd0;
        case (w_seg)
            3'd7:    w_mant = w_mh[10:7];
            3'd6:    w_mant = w_mh[9:6];
            3'd5:    w_mant = w_mh[8:5];
            3'd4:    w_mant = w_mh[7:4];
            3'd3:    w_mant = w_mh[6:3];
            3'd2:    w_mant = w_mh[5:2];
            3'd1:    w_mant = w_mh[4:1];
            default: w_mant = w_mh[3:0];
        endcase
    end

    assign o_mlaw = {~w_sign, ~w_seg, ~w_mant};

endmodule

// File: rtl/lin2mlaw_sync.sv
// Microphone capture: synchronises the BCLK-domain sample flag, edge-detects it and emits a
// one-cycle strobe with the mu-law byte. Define MLAW_OUT_REG_EN to register mlaw_out.
module lin2mlaw_sync
    import mlaw_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    lin2mlaw_sync_if.slave   bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_live;
    logic                   r_armed;
    logic                   r_stb;
    logic                   w_avail;
    logic                   w_rise;
    mlaw8_t                 w_enc;

    assign w_avail = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_avail & ~r_prev & r_armed;

    // r_armed blocks the strobe for a flag already high at reset release; it only sets once
    // the chain has sampled a genuine low (r_live marks the first stage as holding real data).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_live  <= 1'b0;
            r_armed <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.avail_async};
            r_prev  <= w_avail;
            r_live  <= 1'b1;
            if (r_live && !r_sync[0]) begin
                r_armed <= 1'b1;
            end
            r_stb   <= w_rise;
        end
    end

    lin2mlaw_enc u_enc (
        .i_lin  (bus.lin_in),
        .o_mlaw (w_enc)
    );

`ifdef MLAW_OUT_REG_EN
    mlaw8_t r_mlaw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mlaw <= MLAW_SILENCE;
        end else if (w_rise) begin
            r_mlaw <= w_enc;
        end
    end

    assign bus.mlaw_out = r_mlaw;
`else
    assign bus.mlaw_out = w_enc;
`endif

    assign bus.avail_sync = w_avail;
    assign bus.mlaw_stb   = r_stb;

endmodule

// File: tb/tb_lin2mlaw_sync.sv
// Directed bench for lin2mlaw_sync: reset behaviour, encoder vectors, latency, back-to-back
// pulses and asynchronous mid-operation reset. Works with or without MLAW_OUT_REG_EN.
module tb_lin2mlaw_sync;
    import mlaw_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    lin2mlaw_sync_if bus();

    lin2mlaw_sync #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; all driving and sampling happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One flag pulse held for 8 cycles: exactly one strobe carrying the expected byte.
    task automatic applyStimulus(input string tag, input lin13_t lin, input mlaw8_t exp);
        int     strobes;
        mlaw8_t captured;
        strobes  = 0;
        captured = 8'h00;
        bus.lin_in      = lin;
        bus.avail_async = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.mlaw_stb === 1'b1) begin
                strobes++;
                captured = bus.mlaw_out;
            end
        end
        bus.avail_async = 1'b0;
        repeat (4) tick();
        checkOutput({tag, " strobes"}, 16'(strobes), 16'd1);
        checkOutput({tag, " byte"}, {8'h00, captured}, {8'h00, exp});
    endtask

    initial begin
        int     strobes;
        lin13_t b2bLin [6];
        mlaw8_t b2bExp [6];
        mlaw8_t b2bGot [6];
        mlaw8_t midExp;

        b2bLin = '{13'h0000, 13'h1FFF, 13'h0FFF, 13'h1000, 13'h0B4B, 13'h14B4};
        b2bExp = '{8'hFF,    8'h7F,    8'h80,    8'h00,    8'h89,    8'h09};
        b2bGot = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        $display("[TB] start");
        rst_n           = 1'b0;
        bus.avail_async = 1'b1;
        bus.lin_in      = 13'h0000;
        repeat (3) tick();
        checkOutput("reset avail_sync", {15'd0, bus.avail_sync}, 16'd0);
        checkOutput("reset mlaw_stb", {15'd0, bus.mlaw_stb}, 16'd0);
        checkOutput("reset mlaw_out", {8'h00, bus.mlaw_out}, 16'h00FF);

        // Flag high across reset release must not strobe.
        rst_n   = 1'b1;
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mlaw_stb === 1'b1) strobes++;
        end
        checkOutput("release no strobe", 16'(strobes), 16'd0);
        checkOutput("release avail_sync", {15'd0, bus.avail_sync}, 16'd1);
        bus.avail_async = 1'b0;
        repeat (4) tick();

        applyStimulus("enc 0B4B", 13'h0B4B, 8'h89);
        applyStimulus("enc 14B4", 13'h14B4, 8'h09);
        applyStimulus("enc 0000", 13'h0000, 8'hFF);
        applyStimulus("enc 1FFF", 13'h1FFF, 8'h7F);
        applyStimulus("enc 12D2", 13'h12D2, 8'h05);
        applyStimulus("enc 0001", 13'h0001, 8'hFE);
        applyStimulus("enc 0100", 13'h0100, 8'hBE);
        applyStimulus("clip 0FFF", 13'h0FFF, 8'h80);
        applyStimulus("min 1000", 13'h1000, 8'h00);
        applyStimulus("clip 0FF0", 13'h0FF0, 8'h80);

        // Latency: first sampling edge is edge 0, strobe appears after edge SYNC_STAGES.
        bus.lin_in      = 13'h0B4B;
        bus.avail_async = 1'b1;
        for (int c = 0; c < SYNC_STAGES; c++) begin
            tick();
            checkOutput("latency early", {15'd0, bus.mlaw_stb}, 16'd0);
        end
        checkOutput("latency avail_sync", {15'd0, bus.avail_sync}, 16'd1);
        tick();
        checkOutput("latency strobe", {15'd0, bus.mlaw_stb}, 16'd1);
        checkOutput("latency byte", {8'h00, bus.mlaw_out}, 16'h0089);
        tick();
        checkOutput("latency one cycle", {15'd0, bus.mlaw_stb}, 16'd0);
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.mlaw_stb === 1'b1) strobes++;
        end
        checkOutput("long level single strobe", 16'(strobes), 16'd0);
        bus.avail_async = 1'b0;
        repeat (4) tick();

        // Six pulses, 10 cycles apart, flag high for 5 cycles each.
        strobes = 0;
        for (int k = 0; k < 6; k++) begin
            bus.lin_in      = b2bLin[k];
            bus.avail_async = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (c == 4) bus.avail_async = 1'b0;
                if (bus.mlaw_stb === 1'b1) begin
                    strobes++;
                    b2bGot[k] = bus.mlaw_out;
                end
            end
        end
        checkOutput("b2b strobe count", 16'(strobes), 16'd6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("b2b byte %0d", k), {8'h00, b2bGot[k]}, {8'h00, b2bExp[k]});
        end
        repeat (4) tick();

        // Asynchronous reset in the middle of a strobe cycle.
        bus.lin_in      = 13'h14B4;
        bus.avail_async = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        checkOutput("mid strobe before reset", {15'd0, bus.mlaw_stb}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
`ifdef MLAW_OUT_REG_EN
        midExp = 8'hFF;
`else
        midExp = 8'h09;
`endif
        checkOutput("mid reset mlaw_stb", {15'd0, bus.mlaw_stb}, 16'd0);
        checkOutput("mid reset avail_sync", {15'd0, bus.avail_sync}, 16'd0);
        checkOutput("mid reset mlaw_out", {8'h00, bus.mlaw_out}, {8'h00, midExp});
        tick();
        rst_n   = 1'b1;
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.mlaw_stb === 1'b1) strobes++;
        end
        checkOutput("mid release no strobe", 16'(strobes), 16'd0);
        bus.avail_async = 1'b0;
        repeat (4) tick();
        applyStimulus("rearm 0B4B", 13'h0B4B, 8'h89);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
